// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, NZVC flag positions, writeback entry.
// Pure declarations, no latency.
// No flow control of its own.
package cpu_pkg;

  // Predicate encodings carried on the cond field
  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_EQ = 4'd1;
  localparam logic [3:0] COND_NE = 4'd2;
  localparam logic [3:0] COND_CS = 4'd3;
  localparam logic [3:0] COND_CC = 4'd4;
  localparam logic [3:0] COND_MI = 4'd5;
  localparam logic [3:0] COND_PL = 4'd6;
  localparam logic [3:0] COND_VS = 4'd7;
  localparam logic [3:0] COND_VC = 4'd8;
  localparam logic [3:0] COND_HI = 4'd9;
  localparam logic [3:0] COND_LS = 4'd10;
  localparam logic [3:0] COND_GE = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12;
  localparam logic [3:0] COND_GT = 4'd13;
  localparam logic [3:0] COND_LE = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // Bit positions inside the NZVC nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // Register-file index width carried in the writeback entry
  localparam int WB_RD_W = 3;

  typedef struct packed {
    logic [15:0]        data;
    logic [WB_RD_W-1:0] rd;
    logic               we;
  } wb_entry_t;

  // Occupancy of the two-entry skid buffer
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  // Evaluate a condition code against the current NZVC value
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] nzvc);
    logic n, z, v, cy;
    n  = nzvc[FLAG_N];
    z  = nzvc[FLAG_Z];
    v  = nzvc[FLAG_V];
    cy = nzvc[FLAG_C];
    case (c)
      COND_AL: cond_pass = 1'b1;
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = cy;
      COND_CC: cond_pass = ~cy;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = cy & ~z;
      COND_LS: cond_pass = ~cy | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Writeback buffer: single register, or 2-entry skid when ALU_WB_SKID_EN is defined.
// Latency: 1 cycle from accept to out_valid in both builds.
// Backpressure: single-register in_ready = ~out_valid | out_ready; skid in_ready = ~FULL from state flops.
module wb_skid_buf
  import cpu_pkg::*;
#(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

`ifdef ALU_WB_SKID_EN

  buf_state_t   r_state;
  buf_state_t   w_next;
  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic         w_push;
  logic         w_pop;
  logic         w_ld_head;
  logic         w_ld_skid;
  logic         w_head_from_skid;

  // in_ready comes only from the state flops so out_ready never reaches it
  assign in_ready  = (r_state != BUF_FULL);
  assign out_valid = (r_state != BUF_EMPTY);
  assign out_data  = r_head;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Next-state and load selects; a FULL buffer only drains
  always_comb begin
    w_next           = r_state;
    w_ld_head        = 1'b0;
    w_ld_skid        = 1'b0;
    w_head_from_skid = 1'b0;
    case (r_state)
      BUF_EMPTY: begin
        if (w_push) begin
          w_next    = BUF_ONE;
          w_ld_head = 1'b1;
        end
      end
      BUF_ONE: begin
        if (w_push && w_pop) begin
          w_ld_head = 1'b1;
        end else if (w_push) begin
          w_next    = BUF_FULL;
          w_ld_skid = 1'b1;
        end else if (w_pop) begin
          w_next = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (w_pop) begin
          w_next           = BUF_ONE;
          w_head_from_skid = 1'b1;
        end
      end
      default: w_next = BUF_EMPTY;
    endcase
  end

  // Occupancy register
  always_ff @(posedge clk) begin
    if (rst) r_state <= BUF_EMPTY;
    else     r_state <= w_next;
  end

  // Head holds the presented entry; skid catches the one arriving under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_head)             r_head <= in_data;
      else if (w_head_from_skid) r_head <= r_skid;
      if (w_ld_skid)             r_skid <= in_data;
    end
  end

`else

  logic         r_vld;
  logic [W-1:0] r_dat;

  assign in_ready  = ~r_vld | out_ready;
  assign out_valid = r_vld;
  assign out_data  = r_dat;

  // Single pipeline register; a new entry may replace the one being retired
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (in_valid && in_ready) begin
      r_vld <= 1'b1;
      r_dat <= in_data;
    end else if (out_ready) begin
      r_vld <= 1'b0;
    end
  end

`endif

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: NZVC status register, condition predicate, buffered RF write port.
// Latency: accept in t gives out_valid and updated flags/alu_cin in t+1.
// Backpressure: in_ready from wb_skid_buf (ALU_WB_SKID_EN selects registered skid version).
module alu_wb_stage
  import cpu_pkg::*;
#(
  parameter int RD_W = WB_RD_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     alu_sum,
  input  logic [3:0]      alu_nzvc,
  input  logic [RD_W-1:0] rd,
  input  logic            rd_we,
  input  logic            flag_we,
  input  logic [3:0]      cond,
  output logic            alu_cin,
  output logic [3:0]      flags,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_we
);

  // The entry struct carries a fixed-width rd field; reject mismatched builds
  if (RD_W != WB_RD_W) begin : g_rd_w_check
    $error("alu_wb_stage: RD_W must equal cpu_pkg::WB_RD_W");
  end

  logic [3:0] r_flags;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_pass;
  wb_entry_t  w_in_ent;
  wb_entry_t  w_out_ent;

  // Predicate sees the status register before this instruction's own update
  assign w_pass   = cond_pass(cond, r_flags);
  assign w_accept = in_valid & w_in_ready;
  assign w_in_ent = '{data: alu_sum, rd: rd, we: rd_we & w_pass};

  // Status register; a failed predicate suppresses the flag write
  always_ff @(posedge clk) begin
    if (rst)                             r_flags <= 4'b0000;
    else if (w_accept && flag_we && w_pass) r_flags <= alu_nzvc;
  end

  assign flags    = r_flags;
  assign alu_cin  = r_flags[FLAG_C];
  assign in_ready = w_in_ready;

  wb_skid_buf #(
    .W($bits(wb_entry_t))
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (w_in_ready),
    .in_data  (w_in_ent),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (w_out_ent)
  );

  assign wb_data = w_out_ent.data;
  assign wb_rd   = w_out_ent.rd;
  assign wb_we   = w_out_ent.we;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: directed vectors, expected entries queued at accept.
// Monitor pops on every retire (out_valid & out_ready) and compares data/rd/we/latency.
// Works for both buffer builds; in_ready expectations depend on ALU_WB_SKID_EN.
module tb_alu_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_sum;
  logic [3:0]  alu_nzvc;
  logic [2:0]  rd;
  logic        rd_we;
  logic        flag_we;
  logic [3:0]  cond;
  logic        alu_cin;
  logic [3:0]  flags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        wb_we;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  r;
    logic        we;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   chk_lat = 1'b0;
  bit   stream  = 1'b0;

  alu_wb_stage #(.RD_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_sum  (alu_sum),
    .alu_nzvc (alu_nzvc),
    .rd       (rd),
    .rd_we    (rd_we),
    .flag_we  (flag_we),
    .cond     (cond),
    .alu_cin  (alu_cin),
    .flags    (flags),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .wb_data  (wb_data),
    .wb_rd    (wb_rd),
    .wb_we    (wb_we)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer one instruction until accepted; expected entry is hand-supplied
  task automatic send(input logic [15:0] d, input logic [3:0] nz, input logic [2:0] r,
                      input logic rwe, input logic fwe, input logic [3:0] c, input logic exp_we);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    alu_sum  = d;
    alu_nzvc = nz;
    rd       = r;
    rd_we    = rwe;
    flag_we  = fwe;
    cond     = c;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{d: d, r: r, we: exp_we, cyc: cyc + 1});
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    if (!stream || !done) in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each retired entry against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_data", wb_data, e.d);
        chk("wb_rd", wb_rd, e.r);
        chk("wb_we", wb_we, e.we);
        if (chk_lat) chk("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_sum = '0; alu_nzvc = '0; rd = '0;
    rd_we = 1'b0; flag_we = 1'b0; cond = 4'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_flags", flags, 4'b0000);
    chk("rst_cin", alu_cin, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_we", wb_we, 0);
    @(posedge clk); #1;

    // Carry chain: C visible to the next instruction
    chk_lat = 1'b1;
    send(16'h0000, 4'b0101, 3'd1, 1'b1, 1'b1, 4'd0, 1'b1);
    @(negedge clk);
    chk("carry_cin", alu_cin, 1);
    chk("carry_flags", flags, 4'b0101);
    chk("carry_valid", out_valid, 1);
    chk("carry_data", wb_data, 16'h0000);
    @(posedge clk); #1;

    // Predication against Z
    send(16'h1111, 4'b0100, 3'd2, 1'b1, 1'b1, 4'd0, 1'b1);
    chk("pred_setup_flags", flags, 4'b0100);
    send(16'hAAAA, 4'b1000, 3'd3, 1'b1, 1'b1, 4'd2, 1'b0);   // NE false
    chk("ne_flags_kept", flags, 4'b0100);
    send(16'h5555, 4'b1000, 3'd3, 1'b1, 1'b1, 4'd1, 1'b1);   // EQ true
    chk("eq_flags", flags, 4'b1000);
    send(16'h0F0F, 4'b0001, 3'd4, 1'b1, 1'b1, 4'd15, 1'b0);  // NV never
    chk("nv_flags_kept", flags, 4'b1000);
    send(16'h2222, 4'b0000, 3'd5, 1'b1, 1'b0, 4'd12, 1'b1);  // LT: N=1 V=0
    send(16'h3333, 4'b0000, 3'd6, 1'b1, 1'b0, 4'd11, 1'b0);  // GE false
    send(16'h4444, 4'b0000, 3'd7, 1'b1, 1'b0, 4'd9, 1'b0);   // HI: C=0
    send(16'h6666, 4'b0000, 3'd0, 1'b1, 1'b0, 4'd5, 1'b1);   // MI true
    chk("pred_flags_end", flags, 4'b1000);
    drain();

    // Idle: no state change
    repeat (3) @(negedge clk);
    chk("idle_valid", out_valid, 0);
    chk("idle_flags", flags, 4'b1000);
    @(posedge clk); #1;

    // Backpressure: A, B, C offered under stall, released later
    chk_lat = 1'b0;
    out_ready = 1'b0;
    send(16'hA000, 4'b0000, 3'd1, 1'b1, 1'b0, 4'd0, 1'b1);
    fork
      begin
        send(16'hB000, 4'b0000, 3'd2, 1'b1, 1'b0, 4'd0, 1'b1);
        send(16'hC000, 4'b0000, 3'd3, 1'b1, 1'b0, 4'd0, 1'b1);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_hold_valid", out_valid, 1);
          chk("bp_hold_data", wb_data, 16'hA000);
        end
        chk("bp_in_ready_full", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Streaming: 8 back-to-back, each retired one cycle after accept
    chk_lat = 1'b1;
    stream  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] sd;
      logic [2:0]  sr;
      sd = 16'h1000 + 16'(i);
      sr = 3'(i);
      send(sd, 4'b0000, sr, 1'b1, 1'b0, 4'd0, 1'b1);
    end
    stream   = 1'b0;
    in_valid = 1'b0;
    drain();

    // Reset while holding buffered entries
    out_ready = 1'b0;
    send(16'h7777, 4'b0011, 3'd1, 1'b1, 1'b1, 4'd0, 1'b1);
`ifdef ALU_WB_SKID_EN
    send(16'h8888, 4'b0011, 3'd2, 1'b1, 1'b0, 4'd0, 1'b1);
`endif
    @(negedge clk);
    chk("pre_rst_flags", flags, 4'b0011);
    chk("pre_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_flags", flags, 4'b0000);
    chk("mid_rst_cin", alu_cin, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(16'h1234, 4'b0001, 3'd5, 1'b1, 1'b1, 4'd4, 1'b1);   // CC true after reset
    chk("post_rst_flags", flags, 4'b0001);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/alu_wb_stage.md
# alu_wb_stage

Execute-to-writeback stage directly downstream of the 16-bit ALU. Captures the ALU `Sum` and `NZVC` outputs with destination-register metadata. Holds the architectural status register and feeds its C bit back to the ALU `Cin` for ADC/SBC chaining. Applies a 4-bit condition predicate, then delivers results to the register-file write port over a valid/ready handshake.

## Interface
Parameters:
- `RD_W`, default 3: destination register index width.

Ports, clock and reset first:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: upstream ALU operation is valid this cycle.
- `in_ready` out 1: stage accepts this cycle.
- `alu_sum` in 16: ALU result.
- `alu_nzvc` in 4: ALU flags; bit 3 N, bit 2 Z, bit 1 V, bit 0 C.
- `rd` in RD_W: destination register.
- `rd_we` in 1: instruction writes `rd`.
- `flag_we` in 1: instruction updates the status register.
- `cond` in 4: predicate code.
- `alu_cin` out 1: status C bit, to the ALU `Cin`.
- `flags` out 4: architectural NZVC register.
- `out_valid` out 1: writeback entry valid.
- `out_ready` in 1: register file accepts.
- `wb_data` out 16, `wb_rd` out RD_W, `wb_we` out 1: writeback entry.

## Operation
- Accept is `in_valid & in_ready`.
- Predicate `p` is evaluated at accept against the `flags` value before this instruction's own update:
  - 0 AL, 1 EQ Z, 2 NE ~Z, 3 CS C, 4 CC ~C.
  - 5 MI N, 6 PL ~N, 7 VS V, 8 VC ~V.
  - 9 HI C&~Z, 10 LS ~C|Z.
  - 11 GE N==V, 12 LT N!=V, 13 GT ~Z&(N==V), 14 LE Z|(N!=V).
  - 15 NV, never true.
- On accept:
  - Enqueue `{alu_sum, rd, rd_we & p}`.
  - If `flag_we & p`, `flags <= alu_nzvc`.
- A predicated-false instruction still produces an entry, with `wb_we=0`. Data and rd are passed through unchanged.
- `alu_cin` equals `flags[0]` and is combinational from the register.
- No arithmetic is performed here; `alu_sum` is stored as a 16-bit value with no extension.
- Entries leave in order. An entry is retired when `out_valid & out_ready`.
- Outputs are held stable while `out_valid & ~out_ready`.

## Timing
- Reset values:
  - `flags=4'b0000`, `alu_cin=0`.
  - `out_valid=0`, `wb_data=0`, `wb_rd=0`, `wb_we=0`.
  - `in_ready=1`.
- Latency:
  - Accept in cycle t gives `out_valid` in t+1.
  - A flags update from an accept in cycle t is visible on `flags`/`alu_cin` in t+1. Therefore back-to-back ADC in t+1 sees the carry from t.
- Throughput is 1 entry per cycle when `out_ready=1`.
- Buffer states:
  - EMPTY: `in_ready=1`.
  - ONE: `in_ready=1`.
  - FULL (skid only): `in_ready=0`.
- Simultaneous enqueue and dequeue:
  - In ONE, stays ONE with the new data.
  - In FULL, dequeue only; go to ONE.
- `rst` asserted mid-operation drops all buffered entries and clears flags. Any accept in a reset cycle is ignored.
- `in_valid` deasserted with the stage idle: no state change.
- `cond=15` with `flag_we=1`: flags unchanged.

## Configuration
- `ALU_WB_SKID_EN` defined:
  - 2-entry skid buffer.
  - `in_ready` is registered (`~FULL`), with no combinational path from `out_ready`.
- `ALU_WB_SKID_EN` undefined:
  - Single register.
  - `in_ready = ~out_valid | out_ready`, combinational.
- Latency and flag behaviour are identical in both builds.

## Structure
- Shared package `cpu_pkg` holds:
  - The `cond` encodings as named constants (COND_AL … COND_NV).
  - The NZVC bit indices (FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0).
  - The writeback entry struct `{data[15:0], rd, we}`.
- Sub-module `wb_skid_buf` contains the buffering and is parameterised on payload width. The predicate logic and flags register remain in the top level.

## Test plan
- Reset, then idle: `flags=0000`, `out_valid=0`, `in_ready=1`, all wb outputs 0.
- Carry chain:
  - Accept `alu_sum=16'h0000`, `alu_nzvc=0101`, `flag_we=1`, `cond=AL`.
  - Next cycle: `alu_cin=1`, `flags=0101`, `wb_data=0000`.
- Predication:
  - With `flags=0100`, accept `cond=NE`, `rd=3`, `rd_we=1`, `flag_we=1`, `alu_nzvc=1000`.
  - Expect `wb_we=0`, `wb_rd=3`, flags stay `0100`.
  - Then `cond=EQ`: `wb_we=1`, `flags=1000`.
- Backpressure (skid build):
  - Hold `out_ready=0` and offer 3 entries A,B,C.
  - A and B are accepted, `in_ready=0` while C is offered.
  - Release: outputs appear in order A,B,C, with no duplicate or drop.
- Streaming: `out_ready=1`, 8 consecutive accepts, outputs one per cycle, each 1 cycle after its accept.
- Reset mid-stream: `rst` pulse while FULL gives `out_valid=0` and `flags=0000` the next cycle. The first accept after reset emerges normally.
